// File: rtl/proc_defs_pkg.sv
// Shared processor definitions: sequencer state encoding, opcode constants,
// mux-select meanings and small arithmetic helpers.
package proc_defs;

  // Sequencer states, 3-bit encoding (value 7 is unused).
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  // Opcode field values, taken from instruction bits [31:27].
  localparam logic [4:0] OP_AR   = 5'b00000;
  localparam logic [4:0] OP_T    = 5'b00001;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // Write-register / write-data mux selects.
  localparam logic SEL_AR = 1'b0;
  localparam logic SEL_T  = 1'b1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/proc_sequencer_opcode_decode.sv
// Combinational opcode classifier: exactly one of the four outputs is high.
module opcode_decode
  import proc_defs::*;
(
  input  logic [4:0] opcode,
  output logic       is_ar,
  output logic       is_t,
  output logic       is_halt,
  output logic       is_illegal
);

  // Classify the opcode; anything not explicitly known is illegal.
  always_comb begin
    is_ar      = 1'b0;
    is_t       = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_AR:   is_ar      = 1'b1;
      OP_T:    is_t       = 1'b1;
      OP_HALT: is_halt    = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc_sequencer.sv
// Instruction sequencer: fetch/decode/execute/writeback FSM with PC,
// instruction register, fetch wait counter and retired-instruction counter.
module proc_sequencer
  import proc_defs::*;
#(
  parameter logic [31:0] PC_STEP      = 32'd1,
  parameter int unsigned IMEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] startPC,
  input  logic        start,
  input  logic        imem_ack,
  input  logic [31:0] instr_in,
  output logic        imem_req,
  output logic [31:0] pc_out,
  output logic [31:0] ir_out,
  output logic        regWrite,
  output logic        C_ART_reg,
  output logic        C_ART_data,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);

  // The wait counter only needs to hold 0 .. IMEM_TIMEOUT-1.
  localparam int unsigned       WAIT_W    = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic is_ar, is_t, is_halt, is_illegal;
  logic instr_phase;

  opcode_decode u_opcode_decode (
    .opcode     (ir_q[31:27]),
    .is_ar      (is_ar),
    .is_t       (is_t),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          wait_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // An ack always wins, even on the last allowed wait cycle.
        if (imem_ack) begin
          ir_d    = instr_in;
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        if (is_ar || is_t) begin
          state_d = ST_EXECUTE;
        end else if (is_halt) begin
          state_d = ST_HALTED;
        end else if (is_illegal) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_d    = pc_q + PC_STEP;
        cnt_d   = sat_inc32(cnt_q);
        wait_d  = '0;
        state_d = ST_FETCH;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides every transition.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      pc_q    <= startPC;
      ir_q    <= 32'd0;
      cnt_q   <= 32'd0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  // Status and strobe outputs; strobes are suppressed while RESET is high.
  always_comb begin
    instr_phase = (state_q == ST_DECODE) || (state_q == ST_EXECUTE) ||
                  (state_q == ST_WRITEBACK);
    imem_req    = (state_q == ST_FETCH) && !RESET;
    regWrite    = (state_q == ST_WRITEBACK) && !RESET;
    if (instr_phase && is_t) begin
      C_ART_reg  = SEL_T;
      C_ART_data = SEL_T;
    end else begin
      C_ART_reg  = SEL_AR;
      C_ART_data = SEL_AR;
    end
    halted      = (state_q == ST_HALTED);
    fault       = (state_q == ST_FAULT);
    pc_out      = pc_q;
    ir_out      = ir_q;
    instr_count = cnt_q;
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: randomized instruction streams,
// a queue of predicted retirements and an independent retirement monitor.
module tb_proc_sequencer;

  localparam int IMEM_TO = 15;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] startPC;
  logic        start;
  logic        imem_ack;
  logic [31:0] instr_in;
  logic        imem_req;
  logic [31:0] pc_out;
  logic [31:0] ir_out;
  logic        regWrite;
  logic        C_ART_reg;
  logic        C_ART_data;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;

  proc_sequencer #(.PC_STEP(32'd1), .IMEM_TIMEOUT(IMEM_TO)) dut (
    .CLK(CLK), .RESET(RESET), .startPC(startPC), .start(start),
    .imem_ack(imem_ack), .instr_in(instr_in), .imem_req(imem_req),
    .pc_out(pc_out), .ir_out(ir_out), .regWrite(regWrite),
    .C_ART_reg(C_ART_reg), .C_ART_data(C_ART_data), .halted(halted),
    .fault(fault), .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        cart;
    logic [31:0] cnt;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    RESET    = 1'b1;
    startPC  = pc;
    start    = 1'b1;
    imem_ack = 1'b1;
    instr_in = $urandom;
    #1;
    chk1("req_gated_in_reset", imem_req, 1'b0);
    chk1("wr_gated_in_reset", regWrite, 1'b0);
    tick();
    RESET    = 1'b0;
    start    = 1'b0;
    imem_ack = 1'b0;
    m_pc     = pc;
    m_cnt    = 32'd0;
    sb_q.delete();
  endtask

  task automatic check_reset_state(input logic [31:0] pc);
    chk("rst_pc", pc_out, pc);
    chk("rst_ir", ir_out, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chk1("rst_regwrite", regWrite, 1'b0);
    chk1("rst_imem_req", imem_req, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!imem_req && n < 40) begin
      tick();
      n++;
    end
    ok = imem_req;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_imem_req actual=timeout required=imem_req within 40 cycles");
    end
  endtask

  // Wait for a fetch, hold off for 'delay' cycles, then ack with 'instr'.
  // When 'predict' is set the reference model records what should retire.
  task automatic issue(input logic [31:0] instr, input int delay, input bit predict);
    logic [4:0] op;
    exp_t       e;
    bit         ok;
    op = instr[31:27];
    wait_req(ok);
    if (ok) begin
      if (predict && delay < IMEM_TO && (op == 5'd0 || op == 5'd1)) begin
        e.pc   = m_pc;
        e.ir   = instr;
        e.cart = (op == 5'd1);
        e.cnt  = m_cnt;
        e.lat  = 8'(4 + delay);
        sb_q.push_back(e);
        m_pc  = m_pc + 32'd1;
        m_cnt = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
      end
      for (int i = 0; i < delay; i++) begin
        instr_in = $urandom;
        tick();
      end
      imem_ack = 1'b1;
      instr_in = instr;
      tick();
      imem_ack = 1'b0;
      instr_in = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d pending required=0 pending", sb_q.size());
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom;
    return {op, r[26:0]};
  endfunction

  // Retirement monitor: samples on the falling edge, compares against the queue.
  int   req_cnt   = 0;
  int   since_req = 0;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) begin
        req_cnt   = 0;
        since_req = 0;
      end else begin
        if (imem_req) begin
          req_cnt++;
          since_req = 0;
          chk1("cart_reg_in_fetch", C_ART_reg, 1'b0);
          chk1("cart_data_in_fetch", C_ART_data, 1'b0);
        end else begin
          since_req++;
        end
        if (halted || fault) begin
          chk1("cart_reg_terminal", C_ART_reg, 1'b0);
          chk1("cart_data_terminal", C_ART_data, 1'b0);
        end
        if (req_cnt > 0 && !imem_req && since_req <= 3 && sb_q.size() > 0) begin
          chk1("cart_reg_phase", C_ART_reg, sb_q[0].cart);
          chk1("cart_data_phase", C_ART_data, sb_q[0].cart);
        end
        if (regWrite) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_regwrite actual=1 required=0 pc=0x%08h", pc_out);
          end else begin
            mon_e = sb_q.pop_front();
            chk("wb_pc", pc_out, mon_e.pc);
            chk("wb_ir", ir_out, mon_e.ir);
            chk("wb_count", instr_count, mon_e.cnt);
            chk("wb_latency", 32'(req_cnt + since_req), 32'(mon_e.lat));
          end
          req_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] halt_instr;
    logic [31:0] r;
    RESET    = 1'b1;
    start    = 1'b0;
    imem_ack = 1'b0;
    instr_in = 32'd0;
    startPC  = 32'h100;

    // Reset state, then one AR with immediate ack, then a T with 3 wait cycles.
    do_reset(32'h100);
    check_reset_state(32'h100);
    pulse_start();
    issue(mk(5'd0), 0, 1'b1);
    drain();
    chk("ar_pc", pc_out, 32'h101);
    chk("ar_count", instr_count, 32'd1);
    issue(mk(5'd1), 3, 1'b1);
    drain();
    chk("t_pc", pc_out, 32'h102);
    chk("t_count", instr_count, 32'd2);

    // Random AR/T stream with random ack delays, ended by HALT.
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      issue(mk({4'd0, r[0]}), int'($urandom_range(0, 6)), 1'b1);
    end
    halt_instr = mk(5'b11111);
    issue(halt_instr, int'($urandom_range(0, 3)), 1'b1);
    repeat (3) tick();
    drain();
    chk1("halt_halted", halted, 1'b1);
    chk1("halt_fault", fault, 1'b0);
    chk1("halt_req", imem_req, 1'b0);
    chk("halt_pc", pc_out, m_pc);
    chk("halt_count", instr_count, m_cnt);
    chk("halt_ir", ir_out, halt_instr);

    // Start and ack are ignored while halted.
    pulse_start();
    imem_ack = 1'b1;
    instr_in = $urandom;
    tick();
    tick();
    imem_ack = 1'b0;
    repeat (3) tick();
    chk1("halt_start_ignored", imem_req, 1'b0);
    chk1("halt_sticky", halted, 1'b1);
    chk("halt_ir_hold", ir_out, halt_instr);
    chk("halt_pc_hold", pc_out, m_pc);
    chk("halt_count_hold", instr_count, m_cnt);

    // Fetch timeout: 15 cycles without ack.
    do_reset(32'h200);
    check_reset_state(32'h200);
    pulse_start();
    repeat (IMEM_TO - 1) tick();
    chk1("to_last_fetch_req", imem_req, 1'b1);
    chk1("to_last_fetch_nofault", fault, 1'b0);
    tick();
    chk1("to_fault", fault, 1'b1);
    chk1("to_req_low", imem_req, 1'b0);
    chk1("to_not_halted", halted, 1'b0);
    chk("to_pc", pc_out, 32'h200);
    chk("to_count", instr_count, 32'd0);
    imem_ack = 1'b1;
    instr_in = $urandom;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("to_ack_ignored_ir", ir_out, 32'd0);
    chk1("to_fault_sticky", fault, 1'b1);

    // Ack on the 15th fetch cycle still retires; then an illegal opcode faults.
    do_reset(32'h300);
    pulse_start();
    issue(mk(5'd0), IMEM_TO - 1, 1'b1);
    drain();
    chk1("edge_nofault", fault, 1'b0);
    chk("edge_pc", pc_out, 32'h301);
    chk("edge_count", instr_count, 32'd1);
    issue(32'h1000_0000, 0, 1'b1);
    repeat (3) tick();
    chk1("illegal_fault", fault, 1'b1);
    chk1("illegal_not_halted", halted, 1'b0);
    chk1("illegal_req", imem_req, 1'b0);
    chk("illegal_pc", pc_out, 32'h301);
    chk("illegal_count", instr_count, 32'd1);

    // A randomly chosen illegal opcode after a T instruction.
    do_reset(32'h400);
    pulse_start();
    issue(mk(5'd1), int'($urandom_range(0, 4)), 1'b1);
    issue(mk(5'($urandom_range(2, 30))), int'($urandom_range(0, 4)), 1'b1);
    repeat (3) tick();
    drain();
    chk1("rnd_illegal_fault", fault, 1'b1);
    chk("rnd_illegal_pc", pc_out, 32'h401);
    chk("rnd_illegal_count", instr_count, 32'd1);

    // PC wraps modulo 2^32.
    do_reset(32'hFFFF_FFFF);
    pulse_start();
    issue(mk(5'd0), int'($urandom_range(0, 2)), 1'b1);
    drain();
    chk("wrap_pc", pc_out, 32'h0000_0000);
    chk("wrap_count", instr_count, 32'd1);

    // Reset asserted during WRITEBACK: no write, state returns to reset values.
    do_reset(32'h500);
    pulse_start();
    issue(mk(5'd1), 1, 1'b0);
    tick();
    chk1("rwb_cart_exec", C_ART_reg, 1'b1);
    tick();
    RESET   = 1'b1;
    startPC = 32'h600;
    #1;
    chk1("rwb_regwrite_gated", regWrite, 1'b0);
    chk1("rwb_req_gated", imem_req, 1'b0);
    tick();
    RESET = 1'b0;
    check_reset_state(32'h600);
    repeat (3) tick();
    chk1("rwb_stays_idle", imem_req, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter PC_STEP, default 1: amount added to the PC after each retired instruction.
REQ-002 Parameter IMEM_TIMEOUT, default 15: maximum number of FETCH wait cycles without an ack before a fault.
REQ-003 CLK  in  1  the single clock; all state changes on the rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 startPC  in  32  PC value loaded during reset.
REQ-006 start  in  1  one-cycle pulse that begins execution from IDLE.
REQ-007 imem_ack  in  1  instruction memory has valid data on instr_in this cycle.
REQ-008 instr_in  in  32  instruction word from instruction memory.
REQ-009 imem_req  out  1  fetch request to instruction memory.
REQ-010 pc_out  out  32  current PC.
REQ-011 ir_out  out  32  latched instruction register.
REQ-012 regWrite  out  1  register-file write strobe.
REQ-013 C_ART_reg / C_ART_data  out  1 each  write-register and write-data mux selects; 0 selects the AR path, 1 selects the T path.
REQ-014 halted / fault  out  1 each  sticky status flags.
REQ-015 instr_count  out  32  count of retired instructions.

Function
REQ-016 States SHALL be IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED and FAULT, encoded in 3 bits.
REQ-017 Opcode is ir_out[31:27]: AR = 5'b00000, T = 5'b00001, HALT = 5'b11111; every other opcode is illegal.
REQ-018 IDLE: imem_req = 0; start = 1 moves to FETCH on the next edge; start is ignored in every other state.
REQ-019 FETCH: imem_req = 1.
- imem_ack = 1 latches instr_in into ir_out and moves to DECODE.
- The wait counter resets on entry to FETCH.
REQ-020 FETCH with no ack for IMEM_TIMEOUT consecutive cycles moves to FAULT.
REQ-021 An ack arriving in the same cycle the counter reaches IMEM_TIMEOUT SHALL win: the instruction is latched and the state goes to DECODE.
REQ-022 DECODE: AR or T goes to EXECUTE; HALT goes to HALTED; an illegal opcode goes to FAULT.
REQ-023 EXECUTE lasts one cycle, then WRITEBACK.
REQ-024 WRITEBACK lasts one cycle and returns to FETCH.
- regWrite = 1 only in this state.
- pc_out += PC_STEP, modulo 2^32 (0xFFFFFFFF + 1 = 0x00000000).
- instr_count increments and saturates at 0xFFFFFFFF.
REQ-025 C_ART_reg and C_ART_data SHALL equal (opcode == T) in DECODE, EXECUTE and WRITEBACK, and 0 in all other states.
REQ-026 Latency: with ack in the first FETCH cycle, one instruction takes exactly 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
REQ-027 Each additional ack-wait cycle adds exactly 1 cycle to the instruction.
REQ-028 HALTED and FAULT are terminal until RESET; in them imem_req = 0, regWrite = 0, and pc_out, ir_out and instr_count hold.
REQ-029 halted = 1 only in HALTED; fault = 1 only in FAULT.
REQ-030 An imem_ack outside FETCH SHALL be ignored.
REQ-031 regWrite and imem_req SHALL be gated by !RESET, so no write or request is issued in any cycle where RESET is high.

Reset
REQ-032 On a rising edge with RESET = 1, in any state including mid-instruction:
- state = IDLE
- pc_out = startPC
- ir_out = 0
- instr_count = 0
- wait counter = 0
REQ-033 After reset, halted = 0, fault = 0, regWrite = 0 and imem_req = 0.
REQ-034 RESET has priority over start, imem_ack and all state transitions.

Structure
REQ-035 The state encoding, the opcode constants (AR, T, HALT) and the mux-select meanings SHALL live in the shared processor package (proc_defs).
REQ-036 The opcode classifier (opcode -> is_AR / is_T / is_HALT / is_illegal) SHALL be one combinational sub-module named opcode_decode, reused by control_unit.
REQ-037 Everything else (FSM, PC register, IR, wait counter, instruction counter) is a single module of 150-300 lines.

Verification
REQ-038 RESET with startPC = 0x100, then start, then an AR instruction with immediate ack.
- pc_out = 0x101 after 4 cycles.
- regWrite high exactly 1 cycle with C_ART_* = 0.
- instr_count = 1.
REQ-039 T instruction (0x08xxxxxx) with ack delayed 3 cycles.
- Instruction completes in 7 cycles.
- C_ART_reg = C_ART_data = 1 during DECODE through WRITEBACK.
REQ-040 No ack for 15 FETCH cycles -> fault = 1, imem_req = 0, pc_out unchanged.
REQ-041 Ack on exactly the 15th FETCH cycle -> no fault and the instruction retires.
REQ-042 Two AR instructions then HALT (0xF8000000) -> halted = 1, instr_count = 2, and a later start is ignored.
- Illegal opcode 0x10000000 -> fault = 1.
REQ-043 startPC = 0xFFFFFFFF, one AR instruction -> pc_out = 0x00000000.
REQ-044 RESET asserted during WRITEBACK -> regWrite = 0 that cycle, state = IDLE, instr_count = 0, pc_out = startPC.
